// File: rtl/vram_port_if.sv
`default_nettype none
// ============================================================================
// Module      : vram_port_if
// Description : CPU system-bus bundle for the screen-RAM port.
//               master = CPU bus fabric, slave = vram_port.
//   cpu_bank  CPU window bank select        bus_addr  CPU byte address
//   bus_din   CPU write data                bus_dout  read data (0 unless ack)
//   bus_sync  address phase qualifier       bus_we    1 = write
//   bus_wtbt  byte enables {hi, lo}         bus_stb   data strobe
//   bus_ack   access complete
// Revision    : 1.0 - initial release
// ============================================================================
interface vram_port_if;
  logic        cpu_bank;
  logic [15:0] bus_addr;
  logic [15:0] bus_din;
  logic [15:0] bus_dout;
  logic        bus_sync;
  logic        bus_we;
  logic [1:0]  bus_wtbt;
  logic        bus_stb;
  logic        bus_ack;

  modport master (
    output cpu_bank, bus_addr, bus_din, bus_sync, bus_we, bus_wtbt, bus_stb,
    input  bus_dout, bus_ack
  );

  modport slave (
    input  cpu_bank, bus_addr, bus_din, bus_sync, bus_we, bus_wtbt, bus_stb,
    output bus_dout, bus_ack
  );
endinterface
`default_nettype wire

// File: rtl/vram_port.sv
`default_nettype none
// ============================================================================
// Module      : vram_port
// Description : Owner of the single-port 16K x 16 screen RAM. Serves video
//               word fetches with absolute priority and slots queued CPU
//               reads/writes in between, using the sync/stb/ack handshake.
// Ports       :
//   clk_sys, reset        system clock, asynchronous active-high reset
//   vid_req, vram_addr    one-cycle video fetch strobe and word address
//   vram_data             last fetched video word (held between fetches)
//   bus                   CPU bus (vram_port_if.slave)
//   mem_addr/din/we/be    RAM macro address, write data, write strobe, byte en
//   mem_dout              RAM read data, RD_LAT cycles after the address
// Revision    : 1.0 - initial release
// ============================================================================
module vram_port #(
  parameter logic [15:0] WIN_BASE = 16'o040000,
  parameter int          RD_LAT   = 1
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        vid_req,
  input  logic [13:0] vram_addr,
  output logic [15:0] vram_data,
  vram_port_if.slave  bus,
  output logic [13:0] mem_addr,
  output logic [15:0] mem_din,
  output logic        mem_we,
  output logic [1:0]  mem_be,
  input  logic [15:0] mem_dout
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    VRD  = 3'd1,
    CRD  = 3'd2,
    CWR  = 3'd3,
    ACK  = 3'd4
  } state_t;

  // Cycle count at which mem_dout holds the data for the issued address.
  localparam logic [1:0] LAT_LAST = 2'(RD_LAT);

  state_t      state_q;
  logic [1:0]  lat_cnt_q;
  logic        vid_pend_q;
  logic        cpu_pend_q;
  logic        stb_sel_q;
  logic [15:0] vram_data_q;
  logic [15:0] bus_dout_q;
  logic        bus_ack_q;
  logic [13:0] mem_addr_q;
  logic [15:0] mem_din_q;
  logic        mem_we_q;
  logic [1:0]  mem_be_q;

  logic        sel;
  logic        stb_sel;
  logic        cpu_edge;
  logic        vid_go;
  logic [13:0] cpu_waddr;
  logic [1:0]  wr_be;
  logic        unused_addr_lsb;

  assign sel       = bus.bus_sync & (bus.bus_addr[15:14] == WIN_BASE[15:14]);
  assign stb_sel   = bus.bus_stb & sel;
  // One request per strobe: a new one needs stb to drop first.
  assign cpu_edge  = stb_sel & ~stb_sel_q;
  // The incoming strobe is honoured directly so a fetch from IDLE issues in
  // the same cycle it is requested.
  assign vid_go    = vid_pend_q | vid_req;
  assign cpu_waddr = {bus.cpu_bank, bus.bus_addr[13:1]};
  // A write with no byte lanes selected is a full-word write.
  assign wr_be     = (bus.bus_wtbt == 2'b00) ? 2'b11 : bus.bus_wtbt;
  assign unused_addr_lsb = bus.bus_addr[0];

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      lat_cnt_q   <= 2'd0;
      vid_pend_q  <= 1'b0;
      cpu_pend_q  <= 1'b0;
      stb_sel_q   <= 1'b0;
      vram_data_q <= 16'h0000;
      bus_dout_q  <= 16'h0000;
      bus_ack_q   <= 1'b0;
      mem_addr_q  <= 14'h0000;
      mem_din_q   <= 16'h0000;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 2'b00;
    end else begin
      stb_sel_q <= stb_sel;
      mem_we_q  <= 1'b0;
      if (vid_req)  vid_pend_q <= 1'b1;
      if (cpu_edge) cpu_pend_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (vid_go) begin
            state_q    <= VRD;
            mem_addr_q <= vram_addr;
            vid_pend_q <= 1'b0;
            lat_cnt_q  <= 2'd0;
          end else if (cpu_pend_q) begin
            // A fresh edge in the issue cycle is a new request; keep it.
            cpu_pend_q <= cpu_edge;
            mem_addr_q <= cpu_waddr;
            lat_cnt_q  <= 2'd0;
            if (bus.bus_we) begin
              state_q   <= CWR;
              mem_we_q  <= 1'b1;
              mem_be_q  <= wr_be;
              mem_din_q <= bus.bus_din;
            end else begin
              state_q <= CRD;
            end
          end
        end
        VRD: begin
          if (lat_cnt_q == LAT_LAST) begin
            vram_data_q <= mem_dout;
            state_q     <= IDLE;
          end else begin
            lat_cnt_q <= lat_cnt_q + 2'd1;
          end
        end
        CRD: begin
          if (lat_cnt_q == LAT_LAST) begin
            // If stb already fell, finish silently: no ack, no data.
            bus_dout_q <= bus.bus_stb ? mem_dout : 16'h0000;
            bus_ack_q  <= bus.bus_stb;
            state_q    <= ACK;
          end else begin
            lat_cnt_q <= lat_cnt_q + 2'd1;
          end
        end
        CWR: begin
          mem_be_q  <= 2'b00;
          bus_ack_q <= bus.bus_stb;
          state_q   <= ACK;
        end
        ACK: begin
          if (!bus.bus_stb) begin
            bus_ack_q  <= 1'b0;
            bus_dout_q <= 16'h0000;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign vram_data    = vram_data_q;
  assign bus.bus_dout = bus_dout_q;
  assign bus.bus_ack  = bus_ack_q;
  assign mem_addr     = mem_addr_q;
  assign mem_din      = mem_din_q;
  assign mem_we       = mem_we_q;
  assign mem_be       = mem_be_q;

endmodule
`default_nettype wire

// File: tb/tb_vram_port.sv
`default_nettype none
// ============================================================================
// Module      : tb_vram_port
// Description : Self-checking bench for vram_port (RD_LAT = 1). Table of CPU
//               accesses, hand-written multi-cycle sequences (collision, stb
//               drop, async reset) and a random phase checked against a
//               word-array model of the screen RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vram_port;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        vid_req;
  logic [13:0] vram_addr;
  logic [15:0] vram_data;
  logic [13:0] mem_addr;
  logic [15:0] mem_din;
  logic        mem_we;
  logic [1:0]  mem_be;
  logic [15:0] mem_dout;

  always #5 clk_sys = ~clk_sys;

  vram_port_if bus ();

  vram_port #(.WIN_BASE(16'o040000), .RD_LAT(1)) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .vid_req  (vid_req),
    .vram_addr(vram_addr),
    .vram_data(vram_data),
    .bus      (bus),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .mem_we   (mem_we),
    .mem_be   (mem_be),
    .mem_dout (mem_dout)
  );

  // RAM macro: one-cycle read latency, byte-lane writes, bench preload port.
  logic [15:0] ram [0:16383];
  logic        pre_we;
  logic [13:0] pre_addr;
  logic [15:0] pre_data;
  int          we_cnt = 0;
  logic [13:0] we_addr_last = 14'h0;

  always @(posedge clk_sys) begin
    if (pre_we) begin
      ram[pre_addr] <= pre_data;
    end else if (mem_we) begin
      if (mem_be[1]) ram[mem_addr][15:8] <= mem_din[15:8];
      if (mem_be[0]) ram[mem_addr][7:0]  <= mem_din[7:0];
    end
    mem_dout <= ram[mem_addr];
  end

  always @(posedge clk_sys) begin
    if (mem_we) begin
      we_cnt       <= we_cnt + 1;
      we_addr_last <= mem_addr;
    end
  end

  // Expected screen-RAM contents and expected vram_data.
  logic [15:0] model [0:16383];
  logic [15:0] vd_exp;
  int n_chk;
  int n_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  function automatic logic [15:0] pat(input logic [13:0] a);
    return {2'b00, a} ^ 16'hC3A5;
  endfunction

  task automatic preload(input logic [13:0] a, input logic [15:0] d);
    pre_we   = 1'b1;
    pre_addr = a;
    pre_data = d;
    model[a] = d;
    tick();
    pre_we   = 1'b0;
  endtask

  task automatic model_write(input logic [13:0] wa, input logic [15:0] d, input logic [1:0] be);
    logic [1:0] e;
    e = (be == 2'b00) ? 2'b11 : be;
    if (e[1]) model[wa][15:8] = d[15:8];
    if (e[0]) model[wa][7:0]  = d[7:0];
  endtask

  // Video fetch from IDLE: data must appear exactly two edges after vid_req.
  task automatic vid_fetch(input logic [13:0] a);
    vid_req   = 1'b1;
    vram_addr = a;
    tick();
    vid_req   = 1'b0;
    tick();
    chk("vid_early", {16'h0, vram_data}, {16'h0, vd_exp});
    tick();
    vd_exp = model[a];
    chk("vid_data", {16'h0, vram_data}, {16'h0, vd_exp});
    tick();
  endtask

  // One CPU access; lat = edges after the stb-sampling edge until ack, -1 if none.
  task automatic cpu_op(input bit we, input bit bank, input logic [15:0] addr,
                        input logic [15:0] din, input logic [1:0] wtbt,
                        output int lat, output logic [15:0] dout);
    logic [15:0] dout_or;
    lat     = -1;
    dout    = 16'h0;
    dout_or = 16'h0;
    bus.cpu_bank = bank;
    bus.bus_addr = addr;
    bus.bus_din  = din;
    bus.bus_we   = we;
    bus.bus_wtbt = wtbt;
    bus.bus_sync = 1'b1;
    bus.bus_stb  = 1'b1;
    tick();
    for (int n = 1; n <= 8; n++) begin
      tick();
      if (bus.bus_ack) begin
        lat  = n;
        dout = bus.bus_dout;
        break;
      end
      dout_or |= bus.bus_dout;
    end
    if (lat > 0) begin
      tick();
      chk("ack_hold", {31'h0, bus.bus_ack}, 32'h1);
    end else begin
      dout = dout_or;
    end
    bus.bus_stb  = 1'b0;
    bus.bus_sync = 1'b0;
    tick();
    chk("ack_drop", {15'h0, bus.bus_ack, bus.bus_dout}, 32'h0);
    tick();
  endtask

  typedef struct {
    bit          we;
    bit          bank;
    logic [15:0] addr;
    logic [15:0] din;
    logic [1:0]  wtbt;
    int          exp_lat;
    logic [15:0] exp_dout;
  } vec_t;

  vec_t tbl [13];

  initial begin
    int          lat;
    int          we0;
    int          vd_n;
    int          ack_n;
    logic [15:0] dout;
    logic [13:0] wa;

    tbl[0]  = '{1'b1, 1'b1, 16'o040002, 16'hA55A, 2'b11,  2, 16'h0000};
    tbl[1]  = '{1'b0, 1'b1, 16'o040002, 16'h0000, 2'b00,  3, 16'hA55A};
    tbl[2]  = '{1'b1, 1'b1, 16'o040002, 16'h12FF, 2'b10,  2, 16'h0000};
    tbl[3]  = '{1'b0, 1'b1, 16'o040002, 16'h0000, 2'b00,  3, 16'h125A};
    tbl[4]  = '{1'b1, 1'b1, 16'o040002, 16'h3344, 2'b01,  2, 16'h0000};
    tbl[5]  = '{1'b0, 1'b1, 16'o040002, 16'h0000, 2'b00,  3, 16'h1244};
    tbl[6]  = '{1'b1, 1'b0, 16'o040002, 16'h7E81, 2'b00,  2, 16'h0000};
    tbl[7]  = '{1'b0, 1'b0, 16'o040002, 16'h0000, 2'b00,  3, 16'h7E81};
    tbl[8]  = '{1'b0, 1'b1, 16'o040003, 16'h0000, 2'b00,  3, 16'h1244};
    tbl[9]  = '{1'b1, 1'b0, 16'o040000, 16'h0000, 2'b11,  2, 16'h0000};
    tbl[10] = '{1'b1, 1'b0, 16'o100000, 16'hFFFF, 2'b11, -1, 16'h0000};
    tbl[11] = '{1'b0, 1'b0, 16'o100000, 16'h0000, 2'b00, -1, 16'h0000};
    tbl[12] = '{1'b0, 1'b0, 16'o040000, 16'h0000, 2'b00,  3, 16'h0000};

    n_chk = 0;
    n_err = 0;
    vd_exp = 16'h0;
    reset = 1'b1;
    vid_req = 1'b0;
    vram_addr = 14'h0;
    pre_we = 1'b0;
    pre_addr = 14'h0;
    pre_data = 16'h0;
    bus.cpu_bank = 1'b0;
    bus.bus_addr = 16'h0;
    bus.bus_din  = 16'h0;
    bus.bus_sync = 1'b0;
    bus.bus_we   = 1'b0;
    bus.bus_wtbt = 2'b00;
    bus.bus_stb  = 1'b0;
    #1;
    chk("rst_vram_data", {16'h0, vram_data}, 32'h0);
    chk("rst_bus", {15'h0, bus.bus_ack, bus.bus_dout}, 32'h0);
    chk("rst_mem", {13'h0, mem_we, mem_be, mem_addr}, 32'h0);

    for (int b = 0; b < 2; b++)
      for (int w = 0; w < 32; w++) begin
        wa = {b[0], 13'(w)};
        preload(wa, pat(wa));
      end
    preload(14'h1234, 16'hBEEF);
    reset = 1'b0;
    tick();

    // Plain video fetch; no write strobe allowed.
    we0 = we_cnt;
    vid_fetch(14'h1234);
    chk("vid_no_we", we_cnt - we0, 32'h0);

    // Table of CPU accesses.
    for (int i = 0; i < 13; i++) begin
      we0 = we_cnt;
      cpu_op(tbl[i].we, tbl[i].bank, tbl[i].addr, tbl[i].din, tbl[i].wtbt, lat, dout);
      chk($sformatf("tbl%0d_lat", i), lat, tbl[i].exp_lat);
      chk($sformatf("tbl%0d_dout", i), {16'h0, dout}, {16'h0, tbl[i].exp_dout});
      chk($sformatf("tbl%0d_we", i), we_cnt - we0,
          (tbl[i].we && tbl[i].exp_lat > 0) ? 32'h1 : 32'h0);
      if (tbl[i].we && tbl[i].exp_lat > 0) begin
        wa = {tbl[i].bank, tbl[i].addr[13:1]};
        chk($sformatf("tbl%0d_waddr", i), {18'h0, we_addr_last}, {18'h0, wa});
        model_write(wa, tbl[i].din, tbl[i].wtbt);
      end
    end

    // Collision: video and CPU write strobe sampled on the same edge.
    wa = 14'h0005;
    bus.cpu_bank = 1'b0;
    bus.bus_addr = 16'o040012;
    bus.bus_din  = 16'h5A5A;
    bus.bus_we   = 1'b1;
    bus.bus_wtbt = 2'b11;
    bus.bus_sync = 1'b1;
    bus.bus_stb  = 1'b1;
    vid_req      = 1'b1;
    vram_addr    = 14'h2007;
    tick();
    vid_req = 1'b0;
    vd_n  = -1;
    ack_n = -1;
    for (int n = 1; n <= 10; n++) begin
      tick();
      if (vd_n < 0 && vram_data === model[14'h2007]) vd_n = n;
      if (bus.bus_ack) begin
        ack_n = n;
        break;
      end
    end
    chk("coll_vid_lat", vd_n, 2);
    chk("coll_ack_lat", ack_n, 4);
    vd_exp = model[14'h2007];
    model_write(wa, 16'h5A5A, 2'b11);
    bus.bus_stb  = 1'b0;
    bus.bus_sync = 1'b0;
    tick();
    tick();
    cpu_op(1'b0, 1'b0, 16'o040012, 16'h0, 2'b00, lat, dout);
    chk("coll_readback", {16'h0, dout}, {16'h0, model[wa]});

    // Strobe dropped while the write is in flight: write lands, no ack.
    we0 = we_cnt;
    bus.cpu_bank = 1'b0;
    bus.bus_addr = 16'o040010;
    bus.bus_din  = 16'h9876;
    bus.bus_we   = 1'b1;
    bus.bus_wtbt = 2'b11;
    bus.bus_sync = 1'b1;
    bus.bus_stb  = 1'b1;
    tick();
    tick();
    chk("drop_cwr_we", {31'h0, mem_we}, 32'h1);
    bus.bus_stb  = 1'b0;
    bus.bus_sync = 1'b0;
    ack_n = 0;
    for (int n = 0; n < 4; n++) begin
      tick();
      if (bus.bus_ack) ack_n++;
    end
    chk("drop_no_ack", ack_n, 0);
    chk("drop_we_cnt", we_cnt - we0, 32'h1);
    model_write(14'h0004, 16'h9876, 2'b11);
    cpu_op(1'b0, 1'b0, 16'o040010, 16'h0, 2'b00, lat, dout);
    chk("drop_readback", {16'h0, dout}, 32'h9876);

    // Asynchronous reset in the middle of a write.
    we0 = we_cnt;
    bus.cpu_bank = 1'b1;
    bus.bus_addr = 16'o040006;
    bus.bus_din  = 16'hDEAD;
    bus.bus_we   = 1'b1;
    bus.bus_wtbt = 2'b11;
    bus.bus_sync = 1'b1;
    bus.bus_stb  = 1'b1;
    tick();
    tick();
    chk("rstmid_we_before", {31'h0, mem_we}, 32'h1);
    #2;
    reset = 1'b1;
    #1;
    chk("rstmid_we_async", {31'h0, mem_we}, 32'h0);
    chk("rstmid_ack_async", {31'h0, bus.bus_ack}, 32'h0);
    chk("rstmid_vram_data", {16'h0, vram_data}, 32'h0);
    vd_exp = 16'h0;
    tick();
    reset = 1'b0;
    bus.bus_stb  = 1'b0;
    bus.bus_sync = 1'b0;
    tick();
    chk("rstmid_no_write", we_cnt - we0, 32'h0);
    vid_fetch(14'h0010);
    cpu_op(1'b0, 1'b1, 16'o040006, 16'h0, 2'b00, lat, dout);
    chk("rstmid_readback", {16'h0, dout}, {16'h0, model[14'h2003]});

    // Random traffic against the word-array model.
    for (int i = 0; i < 40; i++) begin
      int          op;
      bit          bank;
      int          w;
      logic [15:0] addr;
      logic [15:0] din;
      logic [1:0]  wtbt;
      op   = $urandom_range(0, 3);
      bank = 1'($urandom_range(0, 1));
      w    = $urandom_range(0, 31);
      addr = 16'h4000 | 16'(w << 1) | 16'($urandom_range(0, 1));
      din  = 16'($urandom);
      wtbt = 2'($urandom_range(0, 3));
      wa   = {bank, 13'(w)};
      case (op)
        0: vid_fetch(wa);
        1: begin
          cpu_op(1'b1, bank, addr, din, wtbt, lat, dout);
          chk("rnd_wr_lat", lat, 2);
          model_write(wa, din, wtbt);
        end
        2: begin
          cpu_op(1'b0, bank, addr, din, wtbt, lat, dout);
          chk("rnd_rd_lat", lat, 3);
          chk("rnd_rd_data", {16'h0, dout}, {16'h0, model[wa]});
        end
        default: begin
          addr[15:14] = (w[0]) ? 2'b10 : ((w[1]) ? 2'b11 : 2'b00);
          cpu_op(1'b0, bank, addr, din, wtbt, lat, dout);
          chk("rnd_oow_lat", lat, -1);
          chk("rnd_oow_dout", {16'h0, dout}, 32'h0);
        end
      endcase
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

endmodule
`default_nettype wire
